wb_bram_slave: RTL and testbench

- Wishbone B3 slave: on-chip block-RAM memory with byte selects, classic cycles and registered-feedback incrementing bursts (linear and wrapping).
- Responder counterpart to the CPU-side cache master: serves 4-beat line fills, write-backs and uncached single accesses.
- Sits behind the bus interconnect. Address decode is done upstream; the slave uses only the low ADDR_BITS word-address bits.

---
 rtl/wb_bram_slave_pkg.sv | 30 +++
 rtl/bram_sdp_be.sv | 47 ++++
 rtl/wb_bram_slave.sv | 159 +++++++++++++++
 tb/tb_wb_bram_slave.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bram_slave_pkg.sv
// ----------------------------------------------------------------------------
// wb_bram_slave_pkg
// Shared Wishbone B3 cycle-type (CTI) and burst-type (BTE) encodings, plus a
// helper that returns which low word-address bits advance in a wrap burst.
// ----------------------------------------------------------------------------
package wb_bram_slave_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    // Low address bits that count within a wrap burst; all-zero means linear.
    function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
        logic [3:0] mask;
        mask = 4'b0000;
        unique case (bte)
            BTE_WRAP4:  mask = 4'b0011;
            BTE_WRAP8:  mask = 4'b0111;
            BTE_WRAP16: mask = 4'b1111;
            default:    mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/bram_sdp_be.sv
// ----------------------------------------------------------------------------
// bram_sdp_be
// Simple dual-port block RAM: one synchronous byte-enabled write port and one
// synchronous read port on an independent address. Reading the address being
// written in the same cycle returns the old contents. No reset on the array.
//
// Ports:
//   clk        clock
//   i_we       write enable
//   i_wr_addr  write word address
//   i_be       per-lane byte enables
//   i_wr_data  write data
//   i_rd_addr  read word address (data appears after the next clk edge)
//   o_rd_data  registered read data
// ----------------------------------------------------------------------------
module bram_sdp_be #(
    parameter int unsigned ADDR_BITS = 12,
    parameter int unsigned LANES     = 4
) (
    input  logic                   clk,
    input  logic                   i_we,
    input  logic [ADDR_BITS-1:0]   i_wr_addr,
    input  logic [LANES-1:0]       i_be,
    input  logic [LANES*8-1:0]     i_wr_data,
    input  logic [ADDR_BITS-1:0]   i_rd_addr,
    output logic [LANES*8-1:0]     o_rd_data
);

    localparam int unsigned Depth = 2 ** ADDR_BITS;

    logic [LANES*8-1:0] r_mem [Depth];
    logic [LANES*8-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (i_be[i]) begin
                    r_mem[i_wr_addr][8*i +: 8] <= i_wr_data[8*i +: 8];
                end
            end
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/wb_bram_slave.sv
// ----------------------------------------------------------------------------
// wb_bram_slave
// Wishbone B3 slave in front of a 32-bit block RAM. Handles classic cycles and
// registered-feedback incrementing bursts (linear and 4/8/16-beat wrap), with
// an optional fixed number of wait cycles before the first ack of each cycle.
//
// Ports:
//   clk         clock (Wishbone clock)
//   rst         synchronous reset, active-low
//   wbs_cyc_i   bus cycle valid
//   wbs_stb_i   strobe
//   wbs_addr_i  word address [31:2]; low ADDR_BITS used, sampled at cycle start
//   wbs_cti_i   cycle type (010 continues a burst, anything else ends it)
//   wbs_bte_i   burst type (linear / wrap4 / wrap8 / wrap16)
//   wbs_sel_i   byte selects
//   wbs_we_i    write enable
//   wbs_data_i  write data
//   wbs_data_o  read data, zero whenever ack is low
//   wbs_ack_o   registered acknowledge
// ----------------------------------------------------------------------------
module wb_bram_slave
    import wb_bram_slave_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 12,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic [29:0] wbs_addr_i,
    input  logic [2:0]  wbs_cti_i,
    input  logic [1:0]  wbs_bte_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_data_i,
    output logic [31:0] wbs_data_o,
    output logic        wbs_ack_o
);

    typedef enum logic [1:0] {StIdle, StWait, StBeat, StEnd} state_e;

    localparam logic [3:0] WaitLast = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e               r_state;
    logic [ADDR_BITS-1:0] r_cur_addr;
    logic [3:0]           r_wait_cnt;
    logic                 r_ack;

    state_e               w_state_nxt;
    logic [ADDR_BITS-1:0] w_addr_nxt;
    logic [3:0]           w_wait_nxt;
    logic                 w_ack_nxt;

    logic                 w_beat_done;
    logic                 w_we;
    logic [ADDR_BITS-1:0] w_wrap_mask;
    logic [ADDR_BITS-1:0] w_addr_inc;
    logic [ADDR_BITS-1:0] w_addr_adv;
    logic [31:0]          w_rd_data;
    logic                 w_unused_addr;

    // Upstream decode owns the high address bits.
    assign w_unused_addr = ^wbs_addr_i[29:ADDR_BITS];

    // A beat only counts when ack meets a live cyc and stb on the same edge.
    assign w_beat_done = (r_state == StBeat) && r_ack && wbs_cyc_i && wbs_stb_i;
    assign w_we        = rst && w_beat_done && wbs_we_i;

    // Wrap bursts count in the masked low bits only; the rest of the address is held.
    assign w_wrap_mask = {{(ADDR_BITS-4){1'b0}}, wrap_mask(wbs_bte_i)};
    assign w_addr_inc  = r_cur_addr + {{(ADDR_BITS-1){1'b0}}, 1'b1};
    assign w_addr_adv  = (w_wrap_mask == '0) ? w_addr_inc
                       : ((r_cur_addr & ~w_wrap_mask) | (w_addr_inc & w_wrap_mask));

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_cur_addr;
        w_wait_nxt  = r_wait_cnt;
        w_ack_nxt   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    w_addr_nxt = wbs_addr_i[ADDR_BITS-1:0];
                    w_wait_nxt = 4'd0;
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = StBeat;
                        w_ack_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = StWait;
                    end
                end
            end
            StWait: begin
                if (!wbs_cyc_i) begin
                    w_state_nxt = StIdle;
                end else if (r_wait_cnt == WaitLast) begin
                    w_state_nxt = StBeat;
                    w_ack_nxt   = wbs_stb_i;
                end else begin
                    w_wait_nxt = r_wait_cnt + 4'd1;
                end
            end
            StBeat: begin
                if (!wbs_cyc_i) begin
                    w_state_nxt = StIdle;
                end else if (w_beat_done) begin
                    if (wbs_cti_i == CTI_INCR) begin
                        w_addr_nxt = w_addr_adv;
                        w_ack_nxt  = wbs_stb_i;
                    end else begin
                        w_state_nxt = StEnd;
                    end
                end else begin
                    // Master wait: ack re-asserts one cycle after stb returns.
                    w_ack_nxt = wbs_stb_i;
                end
            end
            StEnd: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_cur_addr <= '0;
            r_wait_cnt <= 4'd0;
            r_ack      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_addr <= w_addr_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_ack      <= w_ack_nxt;
        end
    end

    // Reading the next beat address keeps the RAM one cycle ahead of the ack.
    bram_sdp_be #(
        .ADDR_BITS (ADDR_BITS),
        .LANES     (4)
    ) u_ram (
        .clk       (clk),
        .i_we      (w_we),
        .i_wr_addr (r_cur_addr),
        .i_be      (wbs_sel_i),
        .i_wr_data (wbs_data_i),
        .i_rd_addr (w_addr_nxt),
        .o_rd_data (w_rd_data)
    );

    assign wbs_ack_o  = r_ack;
    assign wbs_data_o = r_ack ? w_rd_data : 32'h0;

endmodule

// File: tb/tb_wb_bram_slave.sv
// ----------------------------------------------------------------------------
// tb_wb_bram_slave
// Directed bench for wb_bram_slave. Two instances: WAIT_CYCLES=0 (dut0) and
// WAIT_CYCLES=2 (dut2) share all bus inputs except cyc. Expected read data is
// queued when a read is issued and popped as acked beats come back.
// ----------------------------------------------------------------------------
module tb_wb_bram_slave;
    import wb_bram_slave_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        cyc0 = 1'b0;
    logic        cyc2 = 1'b0;
    logic        stb  = 1'b0;
    logic        we   = 1'b0;
    logic [29:0] addr = '0;
    logic [2:0]  cti  = CTI_CLASSIC;
    logic [1:0]  bte  = BTE_LINEAR;
    logic [3:0]  sel  = 4'hF;
    logic [31:0] wdat = '0;
    logic [31:0] dat0, dat2;
    logic        ack0, ack2;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb[$];
    logic [31:0] v[$];
    int lat, span;

    wb_bram_slave #(.ADDR_BITS(12), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .wbs_cyc_i(cyc0), .wbs_stb_i(stb), .wbs_addr_i(addr),
        .wbs_cti_i(cti), .wbs_bte_i(bte), .wbs_sel_i(sel), .wbs_we_i(we),
        .wbs_data_i(wdat), .wbs_data_o(dat0), .wbs_ack_o(ack0)
    );

    wb_bram_slave #(.ADDR_BITS(12), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .wbs_cyc_i(cyc2), .wbs_stb_i(stb), .wbs_addr_i(addr),
        .wbs_cti_i(cti), .wbs_bte_i(bte), .wbs_sel_i(sel), .wbs_we_i(we),
        .wbs_data_i(wdat), .wbs_data_o(dat2), .wbs_ack_o(ack2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] beat_cti(input int i, input int n, input bit last_end);
        if (last_end && n == 1) return CTI_CLASSIC;
        if (last_end && i == n - 1) return CTI_END;
        return CTI_INCR;
    endfunction

    task automatic set_cyc(input int d, input logic val);
        if (d == 0) cyc0 = val;
        else cyc2 = val;
    endtask

    // One bus cycle of vals.size() beats. Writes send vals; reads expect vals.
    // last_end=0 leaves cti at INCR on the last beat and drops cyc after it.
    // lat: sample index of the first valid ack; span: sample index when done.
    task automatic burst(input int d, input logic [29:0] a, input bit w, input logic [1:0] bt,
                         input logic [3:0] s, input logic [31:0] vals[$], input bit last_end,
                         input int stall_at, input int stall_len, input string tag,
                         output int lat_o, output int span_o);
        int n = vals.size();
        int i = 0;
        int cnt = 0;
        int stall_left = 0;
        bit done = 1'b0;
        bit valid = 1'b0;
        logic ack_s;
        logic [31:0] dat_s;
        logic [31:0] exp_d;
        lat_o = -1;
        @(posedge clk); #1;
        if (!w) foreach (vals[k]) sb.push_back(vals[k]);
        set_cyc(d, 1'b1);
        stb = 1'b1; we = w; addr = a; bte = bt; sel = s; wdat = vals[0];
        cti = beat_cti(0, n, last_end);
        while (!done) begin
            @(posedge clk); #1;
            cnt++;
            ack_s = (d == 0) ? ack0 : ack2;
            dat_s = (d == 0) ? dat0 : dat2;
            if (stall_left > 0) begin
                chk({tag, "_stall_ack"}, 32'(ack_s), 32'h0);
                stall_left--;
                if (stall_left == 0) stb = 1'b1;
                valid = 1'b0;
            end else begin
                if (valid) begin
                    i++;
                    if (i == n) begin
                        set_cyc(d, 1'b0);
                        stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC;
                        done = 1'b1;
                        if (last_end) chk({tag, "_end_ack"}, 32'(ack_s), 32'h0);
                    end else begin
                        wdat = vals[i];
                        cti = beat_cti(i, n, last_end);
                        if (i == stall_at) begin
                            stb = 1'b0;
                            stall_left = stall_len;
                        end
                    end
                end
                valid = !done && ack_s && stb;
                if (valid) begin
                    if (lat_o < 0) lat_o = cnt;
                    if (!w) begin
                        exp_d = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
                        chk({tag, "_data"}, dat_s, exp_d);
                    end
                end
            end
            if (!done && cnt >= 60) begin
                checks++;
                errors++;
                $error("FAIL %s_timeout: observed beats=%0d expected=%0d", tag, i, n);
                set_cyc(d, 1'b0);
                stb = 1'b0; we = 1'b0;
                sb.delete();
                done = 1'b1;
            end
        end
        span_o = cnt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values while rst is held low.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack0", 32'(ack0), 32'h0);
        chk("rst_dat0", dat0, 32'h0);
        chk("rst_ack2", 32'(ack2), 32'h0);
        chk("rst_dat2", dat2, 32'h0);
        rst = 1'b1;

        // Classic write then read, full and partial byte selects.
        v = '{32'hDEADBEEF};
        burst(0, 30'h010, 1'b1, BTE_LINEAR, 4'hF, v, 1'b1, -1, 0, "wr_full", lat, span);
        chk("wr_full_lat", 32'(lat), 32'd1);
        burst(0, 30'h010, 1'b0, BTE_LINEAR, 4'hF, v, 1'b1, -1, 0, "rd_full", lat, span);
        chk("rd_full_lat", 32'(lat), 32'd1);
        chk("rd_full_span", 32'(span), 32'd2);
        v = '{32'h000000AA};
        burst(0, 30'h010, 1'b1, BTE_LINEAR, 4'h1, v, 1'b1, -1, 0, "wr_byte", lat, span);
        v = '{32'hDEADBEAA};
        burst(0, 30'h010, 1'b0, BTE_LINEAR, 4'hF, v, 1'b1, -1, 0, "rd_byte", lat, span);

        // 4-beat linear burst: back-to-back acks.
        v = '{32'd1, 32'd2, 32'd3, 32'd4};
        burst(0, 30'h020, 1'b1, BTE_LINEAR, 4'hF, v, 1'b1, -1, 0, "wr_lin", lat, span);
        burst(0, 30'h020, 1'b0, BTE_LINEAR, 4'hF, v, 1'b1, -1, 0, "rd_lin", lat, span);
        chk("rd_lin_lat", 32'(lat), 32'd1);
        chk("rd_lin_span", 32'(span), 32'd5);

        // Wrap-4 write from 0x042 lands at 0x042,0x043,0x040,0x041.
        v = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004};
        burst(0, 30'h042, 1'b1, BTE_WRAP4, 4'hF, v, 1'b1, -1, 0, "wr_wrap", lat, span);
        v = '{32'hCCCC0003, 32'hDDDD0004, 32'hAAAA0001, 32'hBBBB0002};
        burst(0, 30'h040, 1'b0, BTE_LINEAR, 4'hF, v, 1'b1, -1, 0, "rd_wrap_lin", lat, span);
        v = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004};
        burst(0, 30'h042, 1'b0, BTE_WRAP4, 4'hF, v, 1'b1, -1, 0, "rd_wrap4", lat, span);

        // Linear burst across the top of memory; high address bits ignored.
        v = '{32'h55555555, 32'h66666666};
        burst(0, 30'h2000_0FFF, 1'b1, BTE_LINEAR, 4'hF, v, 1'b1, -1, 0, "wr_top", lat, span);
        v = '{32'h66666666};
        burst(0, 30'h000, 1'b0, BTE_LINEAR, 4'hF, v, 1'b1, -1, 0, "rd_zero", lat, span);

        // WAIT_CYCLES=2 instance: latency and a mid-burst master stall.
        v = '{32'd10, 32'd11, 32'd12, 32'd13};
        burst(1, 30'h100, 1'b1, BTE_LINEAR, 4'hF, v, 1'b1, -1, 0, "w2_wr", lat, span);
        chk("w2_wr_lat", 32'(lat), 32'd3);
        v = '{32'd11};
        burst(1, 30'h101, 1'b0, BTE_LINEAR, 4'hF, v, 1'b1, -1, 0, "w2_rd", lat, span);
        chk("w2_rd_lat", 32'(lat), 32'd3);
        v = '{32'd10, 32'd11, 32'd12, 32'd13};
        burst(1, 30'h100, 1'b0, BTE_LINEAR, 4'hF, v, 1'b1, 2, 2, "w2_stall", lat, span);
        chk("w2_stall_span", 32'(span), 32'd10);

        // cyc dropped after beat 2 of a write burst: words 3-4 untouched.
        v = '{32'h30, 32'h31, 32'h32, 32'h33};
        burst(0, 30'h030, 1'b1, BTE_LINEAR, 4'hF, v, 1'b1, -1, 0, "pre_abort", lat, span);
        v = '{32'hE0E0E0E0, 32'hE1E1E1E1};
        burst(0, 30'h030, 1'b1, BTE_LINEAR, 4'hF, v, 1'b0, -1, 0, "wr_abort", lat, span);
        @(posedge clk); #1;
        chk("abort_ack", 32'(ack0), 32'h0);
        v = '{32'hE0E0E0E0, 32'hE1E1E1E1, 32'h32, 32'h33};
        burst(0, 30'h030, 1'b0, BTE_LINEAR, 4'hF, v, 1'b1, -1, 0, "rd_abort", lat, span);

        // Reset during a write burst: no write on the reset edge, outputs zero.
        v = '{32'h70, 32'h71};
        burst(0, 30'h070, 1'b1, BTE_LINEAR, 4'hF, v, 1'b1, -1, 0, "pre_rst", lat, span);
        @(posedge clk); #1;
        cyc0 = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'h070; cti = CTI_INCR;
        bte = BTE_LINEAR; sel = 4'hF; wdat = 32'h77770000;
        @(posedge clk); #1;
        chk("rstb_ack", 32'(ack0), 32'h1);
        @(posedge clk); #1;
        wdat = 32'h88880000;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstb_ack_after", 32'(ack0), 32'h0);
        chk("rstb_dat_after", dat0, 32'h0);
        rst = 1'b1; cyc0 = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC;
        v = '{32'h77770000, 32'h71};
        burst(0, 30'h070, 1'b0, BTE_LINEAR, 4'hF, v, 1'b1, -1, 0, "rd_rst", lat, span);
        v = '{32'hDEADBEAA};
        burst(0, 30'h010, 1'b0, BTE_LINEAR, 4'hF, v, 1'b1, -1, 0, "rd_retain", lat, span);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
